// File: rtl/id_ex_skid_reg_pkg.sv
// Shared pipeline definitions for the ID->EX skid register: field widths,
// bubble instruction, occupancy state encoding and the stored payload record.
package id_ex_skid_reg_pkg;

    localparam int INST_WIDTH   = 32;
    localparam int ADDR_WIDTH   = 32;
    localparam int DATA_WIDTH   = 32;
    localparam int LSU_OP_WIDTH = 4;
    localparam int EXU_OP_WIDTH = 6;
    localparam int CSR_OP_WIDTH = 3;
    localparam int REG_WIDTH    = 5;

    localparam logic [INST_WIDTH-1:0] NOP_INST_DEFAULT = 32'h0340_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [INST_WIDTH-1:0]   inst;
        logic [ADDR_WIDTH-1:0]   pc;
        logic [DATA_WIDTH-1:0]   ls_data;
        logic [LSU_OP_WIDTH-1:0] ls_op;
        logic [DATA_WIDTH-1:0]   oprand1;
        logic [DATA_WIDTH-1:0]   oprand2;
        logic [EXU_OP_WIDTH-1:0] ex_op;
        logic [CSR_OP_WIDTH-1:0] csr_op;
        logic [REG_WIDTH-1:0]    rd_wr_addr;
        logic                    rd_wr_en;
    } id_ex_payload_t;

    // Number of held entries implied by a state.
    function automatic logic [1:0] state_occupancy(skid_state_e s);
        logic [1:0] occ;
        case (s)
            ST_EMPTY: occ = 2'd0;
            ST_ONE:   occ = 2'd1;
            ST_FULL:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/id_ex_skid_reg_if.sv
// Decoded-instruction payload bundle passed between ID and EX.
// Modport i receives the bundle, modport o drives it.
interface id_stage_if
    import id_ex_skid_reg_pkg::*;
();
    logic [INST_WIDTH-1:0]   inst;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0]   ls_data;
    logic [LSU_OP_WIDTH-1:0] ls_op;
    logic [DATA_WIDTH-1:0]   oprand1;
    logic [DATA_WIDTH-1:0]   oprand2;
    logic [EXU_OP_WIDTH-1:0] ex_op;
    logic [CSR_OP_WIDTH-1:0] csr_op;
    logic [REG_WIDTH-1:0]    rd_wr_addr;
    logic                    rd_wr_en;

    modport i (
        input inst, pc, ls_data, ls_op, oprand1, oprand2,
              ex_op, csr_op, rd_wr_addr, rd_wr_en
    );

    modport o (
        output inst, pc, ls_data, ls_op, oprand1, oprand2,
               ex_op, csr_op, rd_wr_addr, rd_wr_en
    );
endinterface

// File: rtl/id_ex_skid_reg_entry.sv
// One payload storage slot (MAIN or SKID). Not reset: contents are only
// observed while marked valid, and the bubble mask covers everything else.
module id_ex_entry
    import id_ex_skid_reg_pkg::*;
(
    input  logic           clk,
    input  logic           load,
    input  id_ex_payload_t d,
    output id_ex_payload_t q
);

    // Capture the payload when the control logic selects this slot.
    always_ff @(posedge clk) begin
        if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_skid_reg.sv
// Two-entry ID->EX skid register: fully registered id_ready, 1/cycle
// throughput, flush support and a saturating EX back-pressure counter.
module id_ex_skid_reg
    import id_ex_skid_reg_pkg::*;
#(
    parameter logic [INST_WIDTH-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    id_stage_if.i         id,
    input  logic          id_valid,
    output logic          id_ready,
    id_stage_if.o         ex,
    output logic          ex_valid,
    input  logic          ex_ready,
    input  logic          flush,
    output logic [1:0]    occupancy,
    output logic [31:0]   stall_cnt
);

    skid_state_e    state_r;
    skid_state_e    state_s;
    logic           id_ready_r;
    logic           ex_valid_r;
    logic [1:0]     occupancy_r;
    logic [31:0]    stall_cnt_r;
    logic           accept_s;
    logic           deliver_s;
    logic           main_load_s;
    logic           skid_load_s;
    logic           main_from_skid_s;
    id_ex_payload_t id_payload_s;
    id_ex_payload_t main_d_s;
    id_ex_payload_t main_q_s;
    id_ex_payload_t skid_q_s;
    id_ex_payload_t ex_payload_s;

    assign accept_s  = id_valid & id_ready_r;
    assign deliver_s = ex_valid_r & ex_ready;

    // Pack the incoming interface fields into one payload record.
    always_comb begin
        id_payload_s            = '0;
        id_payload_s.inst       = id.inst;
        id_payload_s.pc         = id.pc;
        id_payload_s.ls_data    = id.ls_data;
        id_payload_s.ls_op      = id.ls_op;
        id_payload_s.oprand1    = id.oprand1;
        id_payload_s.oprand2    = id.oprand2;
        id_payload_s.ex_op      = id.ex_op;
        id_payload_s.csr_op     = id.csr_op;
        id_payload_s.rd_wr_addr = id.rd_wr_addr;
        id_payload_s.rd_wr_en   = id.rd_wr_en;
    end

    // Next-state and slot load decisions; flush overrides everything.
    always_comb begin
        state_s          = state_r;
        main_load_s      = 1'b0;
        skid_load_s      = 1'b0;
        main_from_skid_s = 1'b0;
        if (flush) begin
            state_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_s     = ST_ONE;
                        main_load_s = 1'b1;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && deliver_s) begin
                        state_s     = ST_ONE;
                        main_load_s = 1'b1;
                    end else if (accept_s) begin
                        state_s     = ST_FULL;
                        skid_load_s = 1'b1;
                    end else if (deliver_s) begin
                        state_s = ST_EMPTY;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (deliver_s) begin
                        state_s          = ST_ONE;
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                end
            endcase
        end
    end

    assign main_d_s = main_from_skid_s ? skid_q_s : id_payload_s;

    id_ex_entry u_main (
        .clk  (clk),
        .load (main_load_s),
        .d    (main_d_s),
        .q    (main_q_s)
    );

    id_ex_entry u_skid (
        .clk  (clk),
        .load (skid_load_s),
        .d    (id_payload_s),
        .q    (skid_q_s)
    );

    // State register plus handshake/occupancy flags decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            id_ready_r  <= 1'b1;
            ex_valid_r  <= 1'b0;
            occupancy_r <= 2'd0;
        end else begin
            state_r     <= state_s;
            id_ready_r  <= (state_s != ST_FULL);
            ex_valid_r  <= (state_s != ST_EMPTY);
            occupancy_r <= state_occupancy(state_s);
        end
    end

    // Count cycles EX holds back a valid payload; saturates, survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
        end else if (ex_valid_r && !ex_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    // Present MAIN when valid, otherwise a harmless bubble.
    always_comb begin
        ex_payload_s = '0;
        if (ex_valid_r) begin
            ex_payload_s = main_q_s;
        end else begin
            ex_payload_s      = '0;
            ex_payload_s.inst = NOP_INST;
        end
    end

    assign ex.inst       = ex_payload_s.inst;
    assign ex.pc         = ex_payload_s.pc;
    assign ex.ls_data    = ex_payload_s.ls_data;
    assign ex.ls_op      = ex_payload_s.ls_op;
    assign ex.oprand1    = ex_payload_s.oprand1;
    assign ex.oprand2    = ex_payload_s.oprand2;
    assign ex.ex_op      = ex_payload_s.ex_op;
    assign ex.csr_op     = ex_payload_s.csr_op;
    assign ex.rd_wr_addr = ex_payload_s.rd_wr_addr;
    assign ex.rd_wr_en   = ex_payload_s.rd_wr_en;

    assign id_ready  = id_ready_r;
    assign ex_valid  = ex_valid_r;
    assign occupancy = occupancy_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Directed, table-driven bench for id_ex_skid_reg with hand sequences for
// streaming, stall counting and asynchronous reset.
module tb_id_ex_skid_reg;
    import id_ex_skid_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_ready;
    logic        ex_valid;
    logic        ex_ready = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  occupancy;
    logic [31:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    id_stage_if id_if ();
    id_stage_if ex_if ();

    id_ex_skid_reg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id        (id_if),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .ex        (ex_if),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .flush     (flush),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id_valid;
        logic [31:0] pc;
        logic        ex_ready;
        logic        flush;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [1:0]  exp_occ;
        logic        exp_rdy;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    function automatic logic [31:0] inst_of(logic [31:0] pc);
        return pc ^ 32'h0013_0000;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_id(logic v, logic [31:0] pc);
        id_valid         = v;
        id_if.inst       = inst_of(pc);
        id_if.pc         = pc;
        id_if.ls_data    = ~pc;
        id_if.ls_op      = pc[5:2];
        id_if.oprand1    = pc + 32'd1;
        id_if.oprand2    = pc + 32'd2;
        id_if.ex_op      = pc[7:2];
        id_if.csr_op     = pc[4:2];
        id_if.rd_wr_addr = pc[6:2];
        id_if.rd_wr_en   = 1'b1;
    endtask

    task automatic check_ex(string tag, logic ev, logic [31:0] pc);
        check({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, ev});
        check({tag, ".pc"}, ex_if.pc, ev ? pc : 32'd0);
        check({tag, ".inst"}, ex_if.inst, ev ? inst_of(pc) : 32'h0340_0000);
        check({tag, ".rd_wr_en"}, {31'd0, ex_if.rd_wr_en}, {31'd0, ev});
        check({tag, ".ex_op"}, {26'd0, ex_if.ex_op}, ev ? {26'd0, pc[7:2]} : 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // {id_valid, pc, ex_ready, flush, exp_valid, exp_pc, exp_occ, exp_rdy}
        vecs[0]  = '{1'b1, 32'h1C00_0000, 1'b1, 1'b0, 1'b1, 32'h1C00_0000, 2'd1, 1'b1};
        vecs[1]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 2'd0, 1'b1};
        vecs[2]  = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 2'd1, 1'b1};
        vecs[3]  = '{1'b1, 32'h0000_0104, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 2'd2, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0108, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 2'd2, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0108, 1'b1, 1'b0, 1'b1, 32'h0000_0104, 2'd1, 1'b1};
        vecs[6]  = '{1'b1, 32'h0000_0108, 1'b1, 1'b0, 1'b1, 32'h0000_0108, 2'd1, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 2'd0, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 2'd1, 1'b1};
        vecs[9]  = '{1'b1, 32'h0000_0204, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 2'd2, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0208, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 2'd0, 1'b1};
        vecs[11] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 2'd0, 1'b1};
        vecs[12] = '{1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 2'd1, 1'b1};
        vecs[13] = '{1'b1, 32'h0000_0304, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 2'd0, 1'b1};
        vecs[14] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 2'd0, 1'b1};

        drive_id(1'b0, 32'd0);
        #12;
        check_ex("reset", 1'b0, 32'd0);
        check("reset.occupancy", {30'd0, occupancy}, 32'd0);
        check("reset.id_ready", {31'd0, id_ready}, 32'd1);
        check("reset.stall_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive_id(vecs[i].id_valid, vecs[i].pc);
            ex_ready = vecs[i].ex_ready;
            flush    = vecs[i].flush;
            step();
            check_ex($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
            check($sformatf("vec%0d.occupancy", i), {30'd0, occupancy}, {30'd0, vecs[i].exp_occ});
            check($sformatf("vec%0d.id_ready", i), {31'd0, id_ready}, {31'd0, vecs[i].exp_rdy});
        end
        flush = 1'b0;
        // Stalled edges in the table: vec3, vec4, vec9, vec10.
        check("table.stall_cnt", stall_cnt, 32'd4);

        // Streaming with EX always ready.
        ex_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_id(1'b1, 32'h0000_0400 + 32'(i * 4));
            step();
            check_ex($sformatf("stream%0d", i), 1'b1, 32'h0000_0400 + 32'(i * 4));
            check($sformatf("stream%0d.id_ready", i), {31'd0, id_ready}, 32'd1);
        end
        drive_id(1'b0, 32'd0);
        step();
        check_ex("stream.drain", 1'b0, 32'd0);
        check("stream.stall_cnt", stall_cnt, 32'd4);

        // Fill, then assert reset between edges.
        ex_ready = 1'b0;
        drive_id(1'b1, 32'h0000_0500);
        step();
        drive_id(1'b1, 32'h0000_0504);
        step();
        drive_id(1'b0, 32'd0);
        check("areset.pre_occ", {30'd0, occupancy}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_ex("areset", 1'b0, 32'd0);
        check("areset.occupancy", {30'd0, occupancy}, 32'd0);
        check("areset.id_ready", {31'd0, id_ready}, 32'd1);
        check("areset.stall_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First accept after reset, then 5 stalled cycles.
        drive_id(1'b1, 32'h0000_0600);
        step();
        drive_id(1'b0, 32'd0);
        check_ex("post_reset", 1'b1, 32'h0000_0600);
        check("post_reset.occupancy", {30'd0, occupancy}, 32'd1);
        check("post_reset.stall_cnt", stall_cnt, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("stall%0d.cnt", k), stall_cnt, 32'(k));
            check_ex($sformatf("stall%0d", k), 1'b1, 32'h0000_0600);
        end
        ex_ready = 1'b1;
        step();
        check_ex("stall.release", 1'b0, 32'd0);
        check("stall.final_cnt", stall_cnt, 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_skid_reg.md
ID_EX_SKID_REG -- requirements
Module: id_ex_skid_reg

Interface
REQ-001 Parameter: NOP_INST, 32'h0340_0000, instruction word presented on ex.inst whenever ex_valid=0.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 id  id_stage_if.i  bundle  decoded payload from ID: inst, pc, ls_data, ls_op, oprand1, oprand2, ex_op, csr_op, rd_wr_addr, rd_wr_en; widths per width_param.sv.
REQ-005 id_valid  input  1  payload on id is valid this cycle.
REQ-006 id_ready  output  1  block accepts id payload this cycle; registered.
REQ-007 ex  id_stage_if.o  bundle  payload presented to EX; same fields as id.
REQ-008 ex_valid  output  1  payload on ex is valid.
REQ-009 ex_ready  input  1  EX consumes ex payload this cycle.
REQ-010 flush  input  1  pipeline flush (branch redirect/exception); kills all held entries.
REQ-011 occupancy  output  2  entries held, 0..2.
REQ-012 stall_cnt  output  32  cycles with ex_valid=1 and ex_ready=0, saturating.

Function
REQ-013 Two storage entries: MAIN (drives ex) and SKID; FIFO order preserved, MAIN always older.
REQ-014 State encoding EMPTY (occupancy 0), ONE (MAIN valid), FULL (MAIN+SKID valid); occupancy reflects current state.
REQ-015 Accept = id_valid & id_ready; deliver = ex_valid & ex_ready; both evaluated on same edge.
REQ-016 EMPTY: accept -> ONE, payload to MAIN; latency id->ex one cycle.
REQ-017 ONE: accept & deliver -> ONE, MAIN loads new payload; accept only -> FULL, payload to SKID; deliver only -> EMPTY.
REQ-018 FULL: deliver -> ONE, SKID moves to MAIN; no deliver -> FULL, hold.
REQ-019 id_ready = 1 in EMPTY/ONE, 0 in FULL; computed from registered state only, no combinational path from ex_ready.
REQ-020 ex_valid = 1 in ONE/FULL; ex payload = MAIN contents, stable while ex_valid=1 and ex_ready=0.
REQ-021 ex_valid=0: ex.inst=NOP_INST, rd_wr_en=0, ls_op=0, ex_op=0, csr_op=0, other fields 0.
REQ-022 flush=1: next state EMPTY regardless of accept/deliver; payload accepted that cycle discarded; deliver that cycle still counts as a handshake for EX.
REQ-023 Back-to-back throughput 1/cycle when ex_ready held 1.
REQ-024 stall_cnt increments by 1 per stall cycle, holds at 32'hFFFF_FFFF; not cleared by flush.
REQ-025 id_valid=1 while id_ready=0: payload ignored, no state change.

Reset
REQ-026 rst_n=0 asynchronously: state EMPTY, occupancy=0, ex_valid=0, id_ready=1, stall_cnt=0, ex outputs per REQ-021.
REQ-027 Reset mid-transfer discards both entries; first accept after release follows REQ-016.
REQ-028 Payload storage registers need no reset beyond the bubble masking of REQ-021.

Structure
REQ-029 Width macros (INST/ADDR/DATA/LSU_OP/EXU_OP/CSR_OP/REG_WIDTH) from width_param.sv; state enum and NOP_INST default in shared pipeline package.
REQ-030 One sub-module: id_ex_entry (payload register with load enable) instantiated twice for MAIN and SKID.

Verification
REQ-031 Reset, then id_valid=1 pc=0x1C00_0000 with ex_ready=1 -> ex_valid=1 pc=0x1C00_0000 next cycle, occupancy=1.
REQ-032 ex_ready=0, push pc A=0x100, B=0x104 -> occupancy=2, id_ready=0; C=0x108 offered ignored; ex_ready=1 -> A, B delivered in order, then C accepted.
REQ-033 Stream 8 instructions with ex_ready=1 every cycle -> 8 deliveries in 8 consecutive cycles, id_ready constant 1.
REQ-034 FULL state, flush=1 with id_valid=1 -> next cycle occupancy=0, ex_valid=0, ex.inst=32'h0340_0000, ex.rd_wr_en=0; new payload not delivered.
REQ-035 Hold ex_valid=1, ex_ready=0 for 5 cycles -> stall_cnt=5; ex payload unchanged across all 5 cycles.
REQ-036 Assert rst_n=0 between clock edges while FULL -> outputs take reset values immediately, before next posedge.
